// File: rtl/btn_pkg.sv
// Shared types and sizing helpers for the push-button conditioner.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    // Width needed to hold the larger of two cycle counts.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/btn_conditioner_chan.sv
// One button: 2-flop synchronizer, debounce filter, press pulse and
// hold-to-repeat FSM. All outputs are registered.
module btn_conditioner_chan
    import btn_pkg::*;
#(
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rpt
);

    localparam int   DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int   TMR_W    = cnt_width(HOLD_CYCLES, REPEAT_CYCLES);
    localparam logic RAW_IDLE = (ACTIVE_LOW != 0);

    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] RPT_LAST  = TMR_W'(REPEAT_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic [DB_W-1:0]  db_cnt_reg;
    logic             level_reg;
    logic             press_reg;
    logic             rpt_reg;
    logic [TMR_W-1:0] tmr_reg;
    rpt_state_t       state_reg;

    logic s_norm;
    logic accept;
    logic lvl_rise;
    logic lvl_fall;

    always_comb begin
        s_norm   = sync2_reg ^ RAW_IDLE;
        accept   = (s_norm != level_reg) && (db_cnt_reg == DB_LAST);
        lvl_rise = accept && s_norm;
        lvl_fall = accept && !s_norm;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg  <= RAW_IDLE;
            sync2_reg  <= RAW_IDLE;
            db_cnt_reg <= '0;
            level_reg  <= 1'b0;
            press_reg  <= 1'b0;
            rpt_reg    <= 1'b0;
            tmr_reg    <= '0;
            state_reg  <= IDLE;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            press_reg <= lvl_rise;
            rpt_reg   <= 1'b0;

            // Any agreement with the accepted level discards a pending glitch.
            if (s_norm == level_reg) begin
                db_cnt_reg <= '0;
            end else if (accept) begin
                level_reg  <= s_norm;
                db_cnt_reg <= '0;
            end else begin
                db_cnt_reg <= db_cnt_reg + DB_W'(1);
            end

            // Release takes priority over a timer expiry on the same edge.
            if (lvl_fall) begin
                state_reg <= IDLE;
                tmr_reg   <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (lvl_rise) begin
                            state_reg <= HOLD;
                            tmr_reg   <= '0;
                            rpt_reg   <= 1'b1;
                        end
                    end
                    HOLD: begin
                        if (tmr_reg == HOLD_LAST) begin
                            state_reg <= REPEAT;
                            tmr_reg   <= '0;
                            rpt_reg   <= 1'b1;
                        end else begin
                            tmr_reg <= tmr_reg + TMR_W'(1);
                        end
                    end
                    REPEAT: begin
                        if (tmr_reg == RPT_LAST) begin
                            tmr_reg <= '0;
                            rpt_reg <= 1'b1;
                        end else begin
                            tmr_reg <= tmr_reg + TMR_W'(1);
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        tmr_reg   <= '0;
                    end
                endcase
            end
        end
    end

    assign level = level_reg;
    assign press = press_reg;
    assign rpt   = rpt_reg;

endmodule

// File: rtl/btn_conditioner.sv
// Button conditioner top: one independent conditioning channel per pin,
// bundled onto the PIO-facing level bus and the press/repeat pulse buses.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int WIDTH           = 2,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] btn_press,
    output logic [WIDTH-1:0] btn_repeat
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            btn_conditioner_chan #(
                .ACTIVE_LOW     (ACTIVE_LOW),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .HOLD_CYCLES    (HOLD_CYCLES),
                .REPEAT_CYCLES  (REPEAT_CYCLES)
            ) u_chan (
                .clk  (clk),
                .reset(reset),
                .raw  (btn_raw[gi]),
                .level(btn_level[gi]),
                .press(btn_press[gi]),
                .rpt  (btn_repeat[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short debounce/hold/repeat counts.
module tb_btn_conditioner;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic [1:0] btn_raw = 2'b11;
    logic [1:0] btn_level;
    logic [1:0] btn_press;
    logic [1:0] btn_repeat;

    int checks   = 0;
    int failures = 0;

    btn_conditioner #(
        .WIDTH          (2),
        .ACTIVE_LOW     (1),
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (10),
        .REPEAT_CYCLES  (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .btn_press (btn_press),
        .btn_repeat(btn_repeat)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached got=running exp=finished");
        $fatal(1, "watchdog");
    end

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Release all buttons and let both channels return to idle.
    task automatic settle();
        btn_raw = 2'b11;
        repeat (25) tick();
    endtask

    task automatic test_reset();
        logic [5:0] got;
        #2 reset = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            got = {btn_level, btn_press, btn_repeat};
            checks++;
            if (got !== 6'b0) begin
                failures++;
                $display("FAIL reset_hold k=%0d got=%b exp=%b", k, got, 6'b0);
            end
        end
        reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            got = {btn_level, btn_press, btn_repeat};
            checks++;
            if (got !== 6'b0) begin
                failures++;
                $display("FAIL reset_idle k=%0d got=%b exp=%b", k, got, 6'b0);
            end
        end
        $display("test_reset done checks=%0d", checks);
    endtask

    task automatic test_clean_press();
        logic [5:0] got, exp;
        logic lv, pl;
        btn_raw = 2'b10;
        for (int k = 1; k <= 8; k++) begin
            tick();
            lv  = (k >= 6);
            pl  = (k == 6);
            exp = {1'b0, lv, 1'b0, pl, 1'b0, pl};
            got = {btn_level, btn_press, btn_repeat};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL clean_press k=%0d got=%b exp=%b", k, got, exp);
            end
        end
        btn_raw = 2'b11;
        for (int k = 1; k <= 10; k++) begin
            tick();
            lv  = (k < 6);
            exp = {1'b0, lv, 4'b0};
            got = {btn_level, btn_press, btn_repeat};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL clean_release k=%0d got=%b exp=%b", k, got, exp);
            end
        end
        settle();
        $display("test_clean_press done checks=%0d", checks);
    endtask

    task automatic test_bounce();
        logic [5:0] got;
        for (int k = 0; k < 24; k++) begin
            btn_raw[0] = ((k / 2) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            got = {btn_level, btn_press, btn_repeat};
            checks++;
            if (got !== 6'b0) begin
                failures++;
                $display("FAIL bounce k=%0d got=%b exp=%b", k, got, 6'b0);
            end
        end
        btn_raw = 2'b11;
        for (int k = 0; k < 10; k++) begin
            tick();
            got = {btn_level, btn_press, btn_repeat};
            checks++;
            if (got !== 6'b0) begin
                failures++;
                $display("FAIL bounce_tail k=%0d got=%b exp=%b", k, got, 6'b0);
            end
        end
        settle();
        $display("test_bounce done checks=%0d", checks);
    endtask

    // Acceptance at edge 6; repeats at 16, 19, 22, ...; release after edge 36
    // drops the level at edge 42.
    task automatic test_long_hold();
        logic [5:0] got, exp;
        logic lv, pl, rp;
        btn_raw = 2'b10;
        for (int k = 1; k <= 50; k++) begin
            tick();
            lv  = (k >= 6) && (k < 42);
            pl  = (k == 6);
            rp  = lv && ((k == 6) || ((k >= 16) && ((k - 16) % 3 == 0)));
            exp = {1'b0, lv, 1'b0, pl, 1'b0, rp};
            got = {btn_level, btn_press, btn_repeat};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL long_hold k=%0d got=%b exp=%b", k, got, exp);
            end
            if (k == 36) btn_raw = 2'b11;
        end
        settle();
        $display("test_long_hold done checks=%0d", checks);
    endtask

    // rel_k: edge after which the raw pin is released; the level falls 6 edges later.
    task automatic test_release_in_hold(input int rel_k, input string tag);
        logic [5:0] got, exp;
        logic lv, pl;
        btn_raw = 2'b10;
        for (int k = 1; k <= 35; k++) begin
            tick();
            lv  = (k >= 6) && (k < rel_k + 6);
            pl  = (k == 6);
            exp = {1'b0, lv, 1'b0, pl, 1'b0, pl};
            got = {btn_level, btn_press, btn_repeat};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL %s k=%0d got=%b exp=%b", tag, k, got, exp);
            end
            if (k == rel_k) btn_raw = 2'b11;
        end
        settle();
        $display("%s done checks=%0d", tag, checks);
    endtask

    task automatic test_both_and_reset();
        logic [5:0] got, exp;
        logic [1:0] lv, pl;
        btn_raw = 2'b00;
        for (int k = 1; k <= 8; k++) begin
            tick();
            lv  = (k >= 6) ? 2'b11 : 2'b00;
            pl  = (k == 6) ? 2'b11 : 2'b00;
            exp = {lv, pl, pl};
            got = {btn_level, btn_press, btn_repeat};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL both_press k=%0d got=%b exp=%b", k, got, exp);
            end
        end
        #2 reset = 1'b1;
        #1;
        got = {btn_level, btn_press, btn_repeat};
        checks++;
        if (got !== 6'b0) begin
            failures++;
            $display("FAIL async_reset got=%b exp=%b", got, 6'b0);
        end
        tick();
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            lv  = (k >= 6) ? 2'b11 : 2'b00;
            pl  = (k == 6) ? 2'b11 : 2'b00;
            exp = {lv, pl, pl};
            got = {btn_level, btn_press, btn_repeat};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL reaccept k=%0d got=%b exp=%b", k, got, exp);
            end
        end
        settle();
        $display("test_both_and_reset done checks=%0d", checks);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_hold();
        test_release_in_hold(9, "release_in_hold");
        test_release_in_hold(10, "release_at_expiry");
        test_both_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
